// File: rtl/coord_link_pkg.sv
// rtl/coord_link_pkg.sv - shared constants, FSM states and packet byte mapping for the coordinate link
package coord_link_pkg;

  localparam logic [7:0] PKT_HDR = 8'hAA;
  localparam int         PKT_LEN = 7;

  localparam logic [2:0] FLG_LOCK    = 3'd0;
  localparam logic [2:0] FLG_HIT     = 3'd1;
  localparam logic [2:0] FLG_SEQ_LSB = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } link_state_t;

  // Byte idx of a packet built from a snapshot; the checksum covers B1..B5 only
  function automatic logic [7:0] pkt_byte(
    input logic [2:0] idx,
    input logic [7:0] flags,
    input logic [9:0] x,
    input logic [9:0] y
  );
    logic [7:0] chk;
    chk = flags ^ {6'b0, x[9:8]} ^ x[7:0] ^ {6'b0, y[9:8]} ^ y[7:0];
    case (idx)
      3'd0:    pkt_byte = PKT_HDR;
      3'd1:    pkt_byte = flags;
      3'd2:    pkt_byte = {6'b0, x[9:8]};
      3'd3:    pkt_byte = x[7:0];
      3'd4:    pkt_byte = {6'b0, y[9:8]};
      3'd5:    pkt_byte = y[7:0];
      default: pkt_byte = chk;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serialiser for one byte, BAUD_DIV clocks per bit
module uart_tx_byte
  import coord_link_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       ready
);

  localparam int CNT_W = $clog2(BAUD_DIV);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;

  assign ready = ~active;

  // Start bit is driven on the start pulse; the shifter then walks data LSB first and ends on the stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= 1'b1;
      done     <= 1'b0;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          shreg    <= {1'b1, data};
          tx       <= 1'b0;
          active   <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      end else begin
        // done is raised so that it is high during the last clock of the stop bit
        if (bit_cnt == 4'd9 && baud_cnt == CNT_W'(BAUD_DIV - 2)) begin
          done <= 1'b1;
        end
        if (baud_cnt == CNT_W'(BAUD_DIV - 1)) begin
          baud_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            active <= 1'b0;
            tx     <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx      <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
          end
        end else begin
          baud_cnt <= baud_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/target_coord_uart_tx.sv
// rtl/target_coord_uart_tx.sv - per-frame lock/target coordinate snapshot framed and sent as 8N1 UART
module target_coord_uart_tx
  import coord_link_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD      = 115200,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       is_locked,
  input  logic       center_hit,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  output logic       tx,
  output logic       busy,
  output logic       pkt_sent,
  output logic       overrun
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;

  logic        v_sync_q;
  logic        tick;
  logic        req;
  logic [3:0]  div_cnt;

  link_state_t state;
  logic [2:0]  idx;
  logic [3:0]  seq;
  logic [7:0]  flags_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [7:0]  flags_new;

  logic        start;
  logic [7:0]  byte_data;
  logic        byte_done;
  logic        byte_ready;

  assign tick = v_sync_q & ~v_sync;
  assign req  = tick & (div_cnt == 4'd0);

  // Delayed v_sync for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      v_sync_q <= 1'b0;
    end else begin
      v_sync_q <= v_sync;
    end
  end

  // Frame divider advances on every tick, including ones dropped as overruns
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      if (div_cnt == 4'(FRAME_DIV - 1)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end
  end

  // Flags byte for a snapshot taken this cycle
  always_comb begin
    flags_new = 8'h00;
    flags_new[FLG_LOCK]         = is_locked;
    flags_new[FLG_HIT]          = center_hit;
    flags_new[FLG_SEQ_LSB +: 4] = seq;
  end

  // Packet sequencer: snapshot on request, then feed bytes one at a time to the serialiser
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      seq       <= '0;
      flags_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      start     <= 1'b0;
      byte_data <= '0;
      busy      <= 1'b0;
      pkt_sent  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      start    <= 1'b0;
      pkt_sent <= 1'b0;
      // busy is still high during DONE, so a tick landing there counts as an overrun
      overrun  <= req & busy;
      case (state)
        IDLE: begin
          if (req) begin
            flags_q <= flags_new;
            x_q     <= is_locked ? target_x : 10'd0;
            y_q     <= is_locked ? target_y : 10'd0;
            seq     <= seq + 4'd1;
            busy    <= 1'b1;
            idx     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (byte_ready) begin
            byte_data <= pkt_byte(idx, flags_q, x_q, y_q);
            start     <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (byte_done) begin
            idx <= idx + 3'd1;
            if (idx == 3'(PKT_LEN - 1)) begin
              state <= DONE;
            end else begin
              state <= LOAD;
            end
          end
        end
        DONE: begin
          pkt_sent <= 1'b1;
          busy     <= 1'b0;
          idx      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done),
    .ready(byte_ready)
  );

endmodule

// File: doc/target_coord_uart_tx.md
Name: target_coord_uart_tx

Overview:
Downstream of the pixel mixer's final target coordinate outputs. Once per video frame (or every FRAME_DIV frames) it snapshots the lock state and target coordinates. It frames them as a 7-byte packet and serialises it as 8N1 UART to the STM32 motor controller. It runs on the 25 MHz sys_clk domain alongside VGA_Syncher.

Parameters:
CLK_FREQ, 25_000_000, input clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD = 217 cycles per bit
FRAME_DIV, 1, send one packet every FRAME_DIV frame starts (1..15)

Ports:
clk  in  1  system pixel clock (sys_clk)
reset  in  1  synchronous, active-high reset
v_sync  in  1  VGA vertical sync, active low; its falling edge marks frame start
is_locked  in  1  target lock-on flag
center_hit  in  1  target centred under crosshair
target_x  in  10  locked target x coordinate (0..639)
target_y  in  10  locked target y coordinate (0..479)
tx  out  1  UART serial line, idle high
busy  out  1  high while a packet is in flight
pkt_sent  out  1  one-cycle pulse after the checksum stop bit completes
overrun  out  1  one-cycle pulse when a send request hits while busy

Behaviour:
- Reset values: tx=1, busy=0, pkt_sent=0, overrun=0. Reset also clears the FSM to IDLE, the frame divider, the sequence counter and the baud counter.
- Reset mid-packet aborts the packet immediately; tx returns high on the next cycle.
- Frame tick: register v_sync. tick = prev & ~v_sync, i.e. the falling edge. A frame divider counts ticks 0..FRAME_DIV-1, and a send request fires on the tick where the count is 0.
- Request while busy: the request is dropped, overrun pulses, and the divider still advances.
- Snapshot on an accepted request, in the same cycle as the tick:
  - flags = {seq[3:0], 2'b00, center_hit, is_locked}.
  - x and y are captured as given when is_locked=1, and forced to 0 when is_locked=0.
  - seq increments by 1 mod 16 after each accepted request.
- Packet bytes in order:
  - B0 = 0xAA
  - B1 = flags
  - B2 = {6'b0, x[9:8]}
  - B3 = x[7:0]
  - B4 = {6'b0, y[9:8]}
  - B5 = y[7:0]
  - B6 = B1^B2^B3^B4^B5 (header excluded)
- FSM states:
  - IDLE: on request, latch the snapshot, set busy=1 and go to LOAD.
  - LOAD: present byte[idx] to the byte transmitter with a start pulse; go to WAIT.
  - WAIT: on the byte transmitter's done signal, idx++. If idx was 6, go to DONE, otherwise back to LOAD.
  - DONE: pulse pkt_sent, set busy=0, idx=0 and return to IDLE.
- Byte transmitter:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly BAUD_DIV cycles.
  - done asserts in the final cycle of the stop bit.
  - The next byte's start bit begins 2 cycles later (the LOAD plus start-pulse overhead). No extra idle bits are inserted.
- Latency: tx falls 2 cycles after the accepted tick.
- Packet duration: 70*217 + 6*2 = 15202 cycles.
- Snapshot stability: inputs changing during a packet do not affect that packet.
- A tick coincident with the DONE cycle counts as busy, so it is dropped and overrun pulses.

Decomposition:
- Shared package coord_link_pkg holds:
  - PKT_HDR = 8'hAA and PKT_LEN = 7.
  - Flag bit positions: FLG_LOCK = 0, FLG_HIT = 1, FLG_SEQ_LSB = 4.
  - An enum for the FSM states (IDLE, LOAD, WAIT, DONE).
- One sub-module, uart_tx_byte, contains the baud counter, bit counter and shift register.
  - Inputs: clk, reset, start, data[7:0].
  - Outputs: tx, done, ready.
  - The top FSM sequences bytes through it.

Test Plan:
- Reset, then is_locked=1, center_hit=0, x=320, y=240, one v_sync falling edge -> tx bytes AA 01 01 40 00 F0 B0. tx falls 2 cycles after the edge, each bit lasts 217 cycles, and pkt_sent pulses once.
- is_locked=0, x=639, y=479, second frame -> flags=0x10 (seq=1), x/y bytes 00 00 00 00, checksum 0x10.
- FRAME_DIV=3, 6 v_sync edges -> exactly 2 packets, on ticks 1 and 4; the seq field reads 0 then 1.
- Change target_x from 100 to 200 mid-packet -> the packet still carries 0x00 0x64; the next frame carries 0x00 0xC8.
- Second v_sync edge 5000 cycles after the first (busy) -> overrun pulses for 1 cycle, no second packet starts, and seq is not incremented.
- Assert reset during byte B3 -> tx=1 the next cycle and busy=0. A following v_sync edge sends a complete packet with seq=0.
